// File: rtl/poly_arith_pkg.sv
// rtl/poly_arith_pkg.sv - shared ML-KEM coefficient types, modulus and scaler FSM states
package poly_arith_pkg;

    typedef logic [11:0] coeff_t;

    localparam coeff_t Q           = 12'd3329;
    localparam int     SHIFT_W_DEF = 3;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } mul_pow2_state_e;

endpackage

// File: rtl/mod_mul_by_2.sv
// rtl/mod_mul_by_2.sv - combinational doubling modulo q with a single conditional subtract
module mod_mul_by_2
    import poly_arith_pkg::*;
(
    input  coeff_t x_i,
    output coeff_t y_o
);

    // 2x of a reduced coefficient is below 2q, so one subtract always suffices
    logic [12:0] s;
    logic [12:0] s_red;

    assign s     = {x_i, 1'b0};
    assign s_red = s - {1'b0, Q};
    assign y_o   = (s >= {1'b0, Q}) ? s_red[11:0] : s[11:0];

endmodule

// File: rtl/mod_mul_pow2_seq.sv
// rtl/mod_mul_pow2_seq.sv - sequential x*2^k mod q scaler, one doubling per cycle (option: MOD_MUL_POW2_REDUCE_IN_EN)
module mod_mul_pow2_seq
    import poly_arith_pkg::*;
#(
    parameter int SHIFT_W = SHIFT_W_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  coeff_t             op_i,
    input  logic [SHIFT_W-1:0] k_i,
    input  logic               valid_i,
    output logic               ready_o,
    output coeff_t             op_o,
    output logic               valid_o,
    input  logic               ready_i,
    output logic               busy_o
);

    mul_pow2_state_e    state_q;
    coeff_t             acc_q;
    logic [SHIFT_W-1:0] cnt_q;
    coeff_t             op_q;
    logic               valid_q;
    logic               ready_q;
    logic               busy_q;

    coeff_t             op_in;
    coeff_t             acc_dbl;

`ifdef MOD_MUL_POW2_REDUCE_IN_EN
    // Any 12-bit input is below 2q, so one subtract brings it into [0, q-1]
    coeff_t op_red;
    assign op_red = op_i - Q;
    assign op_in  = (op_i >= Q) ? op_red : op_i;
`else
    assign op_in = op_i;
`endif

    mod_mul_by_2 u_dbl (
        .x_i (acc_q),
        .y_o (acc_dbl)
    );

    // Control FSM with registered handshake outputs; outputs move together with the state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            op_q    <= '0;
            valid_q <= 1'b0;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (valid_i && ready_q) begin
                        acc_q   <= op_in;
                        cnt_q   <= k_i;
                        ready_q <= 1'b0;
                        busy_q  <= 1'b1;
                        if (k_i == '0) begin
                            state_q <= DONE;
                            op_q    <= op_in;
                            valid_q <= 1'b1;
                        end else begin
                            state_q <= SHIFT;
                        end
                    end
                end
                SHIFT: begin
                    // cnt_q is at least 1 here, so the decrement never wraps
                    acc_q <= acc_dbl;
                    cnt_q <= cnt_q - 1'b1;
                    if (cnt_q == SHIFT_W'(1)) begin
                        state_q <= DONE;
                        op_q    <= acc_dbl;
                        valid_q <= 1'b1;
                    end
                end
                DONE: begin
                    // Result held until the consumer takes it; no new accept this cycle
                    if (ready_i) begin
                        state_q <= IDLE;
                        op_q    <= '0;
                        valid_q <= 1'b0;
                        ready_q <= 1'b1;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    valid_q <= 1'b0;
                    ready_q <= 1'b1;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign op_o    = op_q;
    assign valid_o = valid_q;
    assign ready_o = ready_q;
    assign busy_o  = busy_q;

endmodule

// File: tb/tb_mod_mul_pow2_seq.sv
// tb/tb_mod_mul_pow2_seq.sv - directed self-checking bench for mod_mul_pow2_seq
module tb_mod_mul_pow2_seq;

    logic        clk;
    logic        rst_n;
    logic [11:0] op_i;
    logic [2:0]  k_i;
    logic        valid_i;
    logic        ready_o;
    logic [11:0] op_o;
    logic        valid_o;
    logic        ready_i;
    logic        busy_o;

    int n_pass;
    int n_total;
    int cyc;

    mod_mul_pow2_seq #(.SHIFT_W(3)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .op_i    (op_i),
        .k_i     (k_i),
        .valid_i (valid_i),
        .ready_o (ready_o),
        .op_o    (op_o),
        .valid_o (valid_o),
        .ready_i (ready_i),
        .busy_o  (busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    // Present one operand, count cycles from accept to valid_o, check result
    task automatic run(input string tag, input int op, input int k, input int exp_op);
        @(negedge clk);
        op_i    = 12'(op);
        k_i     = 3'(k);
        valid_i = 1'b1;
        chk({tag, "_ready_before"}, int'(ready_o), 1);
        @(posedge clk);
        @(negedge clk);
        valid_i = 1'b0;
        cyc     = 1;
        chk({tag, "_ready_low"}, int'(ready_o), 0);
        chk({tag, "_busy"}, int'(busy_o), 1);
        while (!valid_o && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        chk({tag, "_valid"}, int'(valid_o), 1);
        chk({tag, "_latency"}, cyc, k + 1);
        chk({tag, "_op"}, int'(op_o), exp_op);
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        rst_n   = 1'b0;
        op_i    = '0;
        k_i     = '0;
        valid_i = 1'b0;
        ready_i = 1'b1;

        #12;
        chk("rst_valid", int'(valid_o), 0);
        chk("rst_op", int'(op_o), 0);
        chk("rst_ready", int'(ready_o), 1);
        chk("rst_busy", int'(busy_o), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Basic doubling and halving round-trips
        run("t1_1x2", 1, 1, 2);
        run("t2_1665", 1665, 1, 1);
        run("t2_3328", 3328, 1, 3327);
        // Maximum k = 7: counter wrap boundary
        run("t3_1x128", 1, 7, 128);
        run("t3_3000", 3000, 7, 1165);
        // k = 0 passes through; ready_o back high the next cycle
        run("t4_k0", 3328, 0, 3328);
        @(negedge clk);
        chk("t4_ready_back", int'(ready_o), 1);
        chk("t4_valid_drop", int'(valid_o), 0);

        // Backpressure: hold ready_i low in DONE while pulsing valid_i
        ready_i = 1'b0;
        run("t5_bp", 5, 2, 20);
        for (int i = 0; i < 5; i++) begin
            op_i    = 12'(100 + i);
            k_i     = 3'd0;
            valid_i = (i % 2 == 0);
            @(negedge clk);
            chk("t5_hold_op", int'(op_o), 20);
            chk("t5_hold_valid", int'(valid_o), 1);
            chk("t5_hold_ready", int'(ready_o), 0);
        end
        valid_i = 1'b0;
        ready_i = 1'b1;
        @(negedge clk);
        chk("t5_release_valid", int'(valid_o), 0);
        chk("t5_release_ready", int'(ready_o), 1);
        @(negedge clk);
        chk("t5_no_ghost", int'(valid_o), 0);

        // Asynchronous reset in the middle of SHIFT
        op_i    = 12'd1;
        k_i     = 3'd7;
        valid_i = 1'b1;
        @(negedge clk);
        valid_i = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("t6_in_shift", int'(busy_o), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_rst_valid", int'(valid_o), 0);
        chk("t6_rst_op", int'(op_o), 0);
        chk("t6_rst_ready", int'(ready_o), 1);
        chk("t6_rst_busy", int'(busy_o), 0);
        @(negedge clk);
        rst_n = 1'b1;
        run("t6_recover", 7, 3, 56);

`ifdef MOD_MUL_POW2_REDUCE_IN_EN
        run("t6_reduce", 3400, 0, 71);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
